// File: rtl/vga_rect_fill.sv
// vga_rect_fill: bus initiator that fills an axis-aligned rectangle in the VGA
// frame buffer with one colour by writing the VGA register bank, one bus write
// per cycle, after winning the shared bus through a request/grant handshake.
//
// Ports:
//   CLK, RESET            clock, asynchronous active-low reset
//   START                 one-cycle command strobe (sampled only when idle)
//   X0, Y0, W, H, COLOUR  rectangle origin, size and pixel value
//   BUSY, DONE            command in progress / one-cycle completion pulse
//   BUS_REQ, BUS_GNT      arbiter handshake
//   BUS_ADDR/DATA/WE      shared tri-state bus, driven only while granted
module vga_rect_fill #(
    parameter logic [7:0] VGA_BASE = 8'hB0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [7:0] X0,
    input  logic [6:0] Y0,
    input  logic [7:0] W,
    input  logic [6:0] H,
    input  logic       COLOUR,
    output logic       BUSY,
    output logic       DONE,
    output logic       BUS_REQ,
    input  logic       BUS_GNT,
    inout  wire  [7:0] BUS_ADDR,
    inout  wire  [7:0] BUS_DATA,
    inout  wire        BUS_WE
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_REQ, ST_CLR, ST_COL, ST_PX, ST_PY, ST_FIN, ST_DONE
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] x0_q, x0_d;
    logic [7:0] w_q, w_d;
    logic [6:0] h_q, h_d;
    logic       colour_q, colour_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [7:0] col_q, col_d;
    logic [6:0] row_q, row_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       bus_req_q, bus_req_d;

    logic       bus_state_c;
    logic       drive_c;
    logic [7:0] addr_c;
    logic [7:0] data_c;

    // Bus write decode from registered state; a write only advances when granted.
    always_comb begin
        bus_state_c = 1'b0;
        addr_c      = 8'h00;
        data_c      = 8'h00;
        case (state_q)
            ST_CLR: begin
                bus_state_c = 1'b1;
                addr_c      = VGA_BASE + 8'd1;
                data_c      = {1'b0, y_q};
            end
            ST_COL: begin
                bus_state_c = 1'b1;
                addr_c      = VGA_BASE + 8'd2;
                data_c      = {7'b0, colour_q};
            end
            ST_PX: begin
                bus_state_c = 1'b1;
                addr_c      = VGA_BASE;
                data_c      = x_q;
            end
            ST_PY: begin
                bus_state_c = 1'b1;
                addr_c      = VGA_BASE + 8'd1;
                data_c      = {1'b1, y_q};
            end
            ST_FIN: begin
                bus_state_c = 1'b1;
                addr_c      = VGA_BASE + 8'd1;
                data_c      = {1'b0, y_q};
            end
            default: ;
        endcase
        drive_c = bus_state_c & BUS_GNT;
    end

    assign BUS_ADDR = drive_c ? addr_c : 8'bz;
    assign BUS_DATA = drive_c ? data_c : 8'bz;
    assign BUS_WE   = drive_c ? 1'b1   : 1'bz;

    // Next-state, counter and output logic.
    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        w_d      = w_q;
        h_d      = h_q;
        colour_d = colour_q;
        x_d      = x_q;
        y_d      = y_q;
        col_d    = col_q;
        row_d    = row_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    x0_d     = X0;
                    w_d      = W;
                    h_d      = H;
                    colour_d = COLOUR;
                    x_d      = X0;
                    y_d      = Y0;
                    col_d    = 8'd0;
                    row_d    = 7'd0;
                    state_d  = (W == 8'd0 || H == 7'd0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: if (BUS_GNT) state_d = ST_CLR;
            ST_CLR: if (BUS_GNT) state_d = ST_COL;
            ST_COL: if (BUS_GNT) state_d = ST_PX;
            ST_PX:  if (BUS_GNT) state_d = ST_PY;
            ST_PY: begin
                if (BUS_GNT) begin
                    if (col_q < w_q - 8'd1) begin
                        col_d   = col_q + 8'd1;
                        x_d     = x_q + 8'd1;
                        state_d = ST_PX;
                    end else if (row_q < h_q - 7'd1) begin
                        col_d   = 8'd0;
                        x_d     = x0_q;
                        row_d   = row_q + 7'd1;
                        y_d     = y_q + 7'd1;
                        state_d = ST_PX;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN:  if (BUS_GNT) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // DONE trails the DONE state by one cycle, when BUSY has already dropped.
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_q == ST_DONE);
        bus_req_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            x0_q      <= 8'd0;
            w_q       <= 8'd0;
            h_q       <= 7'd0;
            colour_q  <= 1'b0;
            x_q       <= 8'd0;
            y_q       <= 7'd0;
            col_q     <= 8'd0;
            row_q     <= 7'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bus_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            w_q       <= w_d;
            h_q       <= h_d;
            colour_q  <= colour_d;
            x_q       <= x_d;
            y_q       <= y_d;
            col_q     <= col_d;
            row_q     <= row_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bus_req_q <= bus_req_d;
        end
    end

    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign BUS_REQ = bus_req_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Testbench for vga_rect_fill: expected bus writes and DONE latencies are queued
// by the stimulus; a negedge monitor pops and compares them as the DUT acts.
module tb_vga_rect_fill;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [7:0] w;
    logic [6:0] h;
    logic       colour;
    logic       busy;
    logic       done;
    logic       bus_req;
    logic       bus_gnt;
    wire  [7:0] bus_addr;
    wire  [7:0] bus_data;
    wire        bus_we;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int          cyc       = 0;
    int          start_cyc = 0;
    logic [15:0] exp_q[$];
    int          lat_q[$];
    logic [15:0] mon_e;
    logic        req_seen = 1'b0;

    vga_rect_fill #(.VGA_BASE(8'hB0)) dut (
        .CLK(clk), .RESET(rst_n), .START(start),
        .X0(x0), .Y0(y0), .W(w), .H(h), .COLOUR(colour),
        .BUSY(busy), .DONE(done), .BUS_REQ(bus_req), .BUS_GNT(bus_gnt),
        .BUS_ADDR(bus_addr), .BUS_DATA(bus_data), .BUS_WE(bus_we)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every granted write and every DONE pulse is scored here.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus_req === 1'b1) req_seen = 1'b1;
            if (bus_we === 1'b1) begin
                chk("gnt_while_driving", 32'(bus_gnt), 32'd1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got %h/%h expected none", bus_addr, bus_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("bus_write", {16'h0, bus_addr, bus_data}, {16'h0, mon_e});
                end
            end
            if (done === 1'b1) begin
                chk("busy_at_done", 32'(busy), 32'd0);
                if (lat_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got pulse expected none");
                end else begin
                    chk("done_latency", 32'(cyc - start_cyc), 32'(lat_q.pop_front()));
                end
            end
        end
    end

    task automatic push(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    // Expected writes for a row-major fill; extra = stall cycles added to latency.
    task automatic exp_fill(input logic [7:0] fx, input logic [6:0] fy,
                            input logic [7:0] fw, input logic [6:0] fh,
                            input logic fc, input int extra);
        push(8'hB1, {1'b0, fy});
        push(8'hB2, {7'b0, fc});
        for (int r = 0; r < int'(fh); r++) begin
            for (int c = 0; c < int'(fw); c++) begin
                push(8'hB0, 8'(fx + 8'(c)));
                push(8'hB1, {1'b1, 7'(fy + 7'(r))});
            end
        end
        push(8'hB1, {1'b0, 7'(fy + fh - 7'd1)});
        lat_q.push_back(2 * int'(fw) * int'(fh) + 5 + extra);
    endtask

    task automatic issue(input logic [7:0] ix, input logic [6:0] iy,
                         input logic [7:0] iw, input logic [6:0] ih, input logic ic);
        @(posedge clk); #1;
        x0 = ix; y0 = iy; w = iw; h = ih; colour = ic; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
        @(negedge clk);
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("writes_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; bus_gnt = 1'b1;
        x0 = 8'd0; y0 = 7'd0; w = 8'd0; h = 7'd0; colour = 1'b0;
        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_req", 32'(bus_req), 32'd0);
        chk("reset_we_z", 32'(bus_we === 1'b1), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Single pixel (5,3) colour 1
        push(8'hB1, 8'h03); push(8'hB2, 8'h01); push(8'hB0, 8'h05);
        push(8'hB1, 8'h83); push(8'hB1, 8'h03);
        lat_q.push_back(7);
        issue(8'd5, 7'd3, 8'd1, 7'd1, 1'b1);
        wait_done(20);

        // 3x2 box at (10,20)
        exp_fill(8'd10, 7'd20, 8'd3, 7'd2, 1'b0, 0);
        issue(8'd10, 7'd20, 8'd3, 7'd2, 1'b0);
        wait_done(40);

        // Zero width: DONE next cycle, no bus request at all
        req_seen = 1'b0;
        lat_q.push_back(1);
        issue(8'd7, 7'd9, 8'd0, 7'd5, 1'b1);
        wait_done(5);
        chk("zero_no_req", 32'(req_seen), 32'd0);

        // Grant stall: drop grant for 3 cycles during the first PY
        exp_fill(8'd20, 7'd7, 8'd2, 7'd1, 1'b1, 3);
        issue(8'd20, 7'd7, 8'd2, 7'd1, 1'b1);
        repeat (4) @(posedge clk);
        #1 bus_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_we_z", 32'(bus_we === 1'b1), 32'd0);
            chk("stall_req", 32'(bus_req), 32'd1);
        end
        @(posedge clk);
        #1 bus_gnt = 1'b1;
        wait_done(30);

        // Wrap at X=255, Y=127
        push(8'hB1, 8'h7F); push(8'hB2, 8'h01);
        push(8'hB0, 8'hFF); push(8'hB1, 8'hFF);
        push(8'hB0, 8'h00); push(8'hB1, 8'hFF);
        push(8'hB1, 8'h7F);
        lat_q.push_back(9);
        issue(8'd255, 7'd127, 8'd2, 7'd1, 1'b1);
        wait_done(20);

        // Reset during the first PX of a 4x4 fill
        exp_fill(8'd40, 7'd50, 8'd4, 7'd4, 1'b1, 0);
        issue(8'd40, 7'd50, 8'd4, 7'd4, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("px_driving", 32'(bus_we === 1'b1), 32'd1);
        chk("px_addr", 32'(bus_addr), 32'h0000_00B0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_we_z", 32'(bus_we === 1'b1), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        exp_q.delete();
        lat_q.delete();
        @(negedge clk); rst_n = 1'b1;

        // Full 4x4 fill after reset release
        exp_fill(8'd3, 7'd4, 8'd4, 7'd4, 1'b0, 0);
        issue(8'd3, 7'd4, 8'd4, 7'd4, 1'b0);
        wait_done(60);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
